// File: rtl/clint_if.sv
// Bundles the decode/execute, CSR and ctrl-facing signals of the clint sequencer.
// slave = clint itself, master = the surrounding pipeline/CSR environment.
interface clint_if #(
    parameter int INST_ADDR_W = 32,
    parameter int INT_W       = 8
) ();
    logic [31:0]            inst_i;
    logic [INST_ADDR_W-1:0] inst_addr_i;
    logic                   jump_flag_i;
    logic [INST_ADDR_W-1:0] jump_addr_i;
    logic [INT_W-1:0]       int_flag_i;
    logic                   global_int_en_i;
    logic [INST_ADDR_W-1:0] csr_mtvec_i;
    logic [INST_ADDR_W-1:0] csr_mepc_i;
    logic [INST_ADDR_W-1:0] csr_mstatus_i;
    logic                   hold_flag_o;
    logic                   we_o;
    logic [11:0]            waddr_o;
    logic [INST_ADDR_W-1:0] data_o;
    logic                   int_assert_o;
    logic [INST_ADDR_W-1:0] int_addr_o;

    modport slave (
        input  inst_i, inst_addr_i, jump_flag_i, jump_addr_i, int_flag_i,
        input  global_int_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o
    );

    modport master (
        output inst_i, inst_addr_i, jump_flag_i, jump_addr_i, int_flag_i,
        output global_int_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o
    );
endinterface

// File: rtl/clint.sv
// clint: core-local exception/interrupt sequencer (mepc, mstatus, mcause writes, then redirect).
// Define CLINT_EBREAK_EN to treat EBREAK as a synchronous exception with cause 3.
module clint #(
    parameter int INST_ADDR_W = 32,
    parameter int INT_W       = 8
) (
    input  logic   clk,
    input  logic   rst,
    clint_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEPC    = 3'd1,
        S_MSTATUS = 3'd2,
        S_MCAUSE  = 3'd3,
        S_JUMP    = 3'd4,
        S_MRET    = 3'd5
    } state_t;

    localparam logic [31:0]            INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0]            INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0]            INST_MRET   = 32'h3020_0073;
    localparam logic [11:0]            CSR_MSTATUS = 12'h300;
    localparam logic [11:0]            CSR_MEPC    = 12'h341;
    localparam logic [11:0]            CSR_MCAUSE  = 12'h342;
    localparam logic [INST_ADDR_W-1:0] CAUSE_ECALL  = INST_ADDR_W'(11);
    localparam logic [INST_ADDR_W-1:0] CAUSE_EBREAK = INST_ADDR_W'(3);
    localparam logic [INST_ADDR_W-1:0] CAUSE_TIMER  = {1'b1, {(INST_ADDR_W-4){1'b0}}, 3'd7};

    // Trap entry: MPIE takes MIE, MIE is cleared.
    function automatic logic [INST_ADDR_W-1:0] mstatus_trap(input logic [INST_ADDR_W-1:0] s);
        logic [INST_ADDR_W-1:0] r;
        r    = s;
        r[7] = s[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // Trap return: MIE takes MPIE, MPIE is set.
    function automatic logic [INST_ADDR_W-1:0] mstatus_mret(input logic [INST_ADDR_W-1:0] s);
        logic [INST_ADDR_W-1:0] r;
        r    = s;
        r[3] = s[7];
        r[7] = 1'b1;
        return r;
    endfunction

    state_t                 r_state;
    state_t                 w_next_state;
    logic [INST_ADDR_W-1:0] r_epc;
    logic [INST_ADDR_W-1:0] w_epc_next;
    logic [INST_ADDR_W-1:0] r_cause;
    logic [INST_ADDR_W-1:0] w_cause_next;
    logic                   r_tgt_mepc;
    logic                   w_tgt_mepc_next;

    logic [INT_W-1:0]       w_int_flag;
    logic                   w_is_ecall;
    logic                   w_is_ebreak;
    logic                   w_sync_req;
    logic                   w_async_req;
    logic                   w_mret_req;
    logic                   w_idle;

    logic                   w_hold;
    logic                   w_we;
    logic [11:0]            w_waddr;
    logic [INST_ADDR_W-1:0] w_data;
    logic                   w_int_assert;
    logic [INST_ADDR_W-1:0] w_int_addr;

    assign w_int_flag  = bus.int_flag_i;
    assign w_idle      = (r_state == S_IDLE);
    assign w_is_ecall  = (bus.inst_i == INST_ECALL);
`ifdef CLINT_EBREAK_EN
    assign w_is_ebreak = (bus.inst_i == INST_EBREAK);
`else
    assign w_is_ebreak = 1'b0;
`endif
    assign w_sync_req  = w_is_ecall | w_is_ebreak;
    assign w_async_req = (|w_int_flag) & bus.global_int_en_i;
    assign w_mret_req  = (bus.inst_i == INST_MRET);

    // Next-state logic and capture of the trap PC, cause and redirect target select.
    always_comb begin
        w_next_state    = r_state;
        w_epc_next      = r_epc;
        w_cause_next    = r_cause;
        w_tgt_mepc_next = r_tgt_mepc;
        case (r_state)
            S_IDLE: begin
                if (w_sync_req) begin
                    w_next_state = S_MEPC;
                    w_epc_next   = bus.inst_addr_i;
                    if (w_is_ebreak) begin
                        w_cause_next = CAUSE_EBREAK;
                    end else begin
                        w_cause_next = CAUSE_ECALL;
                    end
                end else if (w_async_req) begin
                    w_next_state = S_MEPC;
                    w_cause_next = CAUSE_TIMER;
                    // An interrupt must resume at the redirect target if execute is jumping.
                    if (bus.jump_flag_i) begin
                        w_epc_next = bus.jump_addr_i;
                    end else begin
                        w_epc_next = bus.inst_addr_i;
                    end
                end else if (w_mret_req) begin
                    w_next_state = S_MRET;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MEPC:    w_next_state = S_MSTATUS;
            S_MSTATUS: w_next_state = S_MCAUSE;
            S_MCAUSE: begin
                w_next_state    = S_JUMP;
                w_tgt_mepc_next = 1'b0;
            end
            S_MRET: begin
                w_next_state    = S_JUMP;
                w_tgt_mepc_next = 1'b1;
            end
            S_JUMP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // CSR write port and redirect decode, driven from the registered state only.
    always_comb begin
        w_we         = 1'b0;
        w_waddr      = 12'h000;
        w_data       = {INST_ADDR_W{1'b0}};
        w_int_assert = 1'b0;
        w_int_addr   = {INST_ADDR_W{1'b0}};
        case (r_state)
            S_MEPC: begin
                w_we    = 1'b1;
                w_waddr = CSR_MEPC;
                w_data  = r_epc;
            end
            S_MSTATUS: begin
                w_we    = 1'b1;
                w_waddr = CSR_MSTATUS;
                w_data  = mstatus_trap(bus.csr_mstatus_i);
            end
            S_MCAUSE: begin
                w_we    = 1'b1;
                w_waddr = CSR_MCAUSE;
                w_data  = r_cause;
            end
            S_MRET: begin
                w_we    = 1'b1;
                w_waddr = CSR_MSTATUS;
                w_data  = mstatus_mret(bus.csr_mstatus_i);
            end
            S_JUMP: begin
                w_int_assert = 1'b1;
                if (r_tgt_mepc) begin
                    w_int_addr = bus.csr_mepc_i;
                end else begin
                    w_int_addr = bus.csr_mtvec_i;
                end
            end
            default: begin
                w_we         = 1'b0;
                w_int_assert = 1'b0;
            end
        endcase
    end

    // Hold is raised in the detect cycle itself and forced low while reset is asserted.
    assign w_hold = ~rst & ((w_idle & (w_sync_req | w_async_req | w_mret_req)) | ~w_idle);

    // State and latched trap information; reset abandons any partial sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_epc      <= {INST_ADDR_W{1'b0}};
            r_cause    <= {INST_ADDR_W{1'b0}};
            r_tgt_mepc <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_epc      <= w_epc_next;
            r_cause    <= w_cause_next;
            r_tgt_mepc <= w_tgt_mepc_next;
        end
    end

    assign bus.hold_flag_o  = w_hold;
    assign bus.we_o         = w_we;
    assign bus.waddr_o      = w_waddr;
    assign bus.data_o       = w_data;
    assign bus.int_assert_o = w_int_assert;
    assign bus.int_addr_o   = w_int_addr;

endmodule
